shell_reply_tx: RTL and testbench



---
 rtl/shell_pkg.sv | 34 +++
 rtl/uart_tx_byte.sv | 83 ++++++++
 rtl/shell_reply_tx.sv | 151 +++++++++++++++
 tb/tb_shell_reply_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shell_pkg.sv
// shell_pkg: shared definitions for the UART command shell.
//   - ASCII constants used when formatting replies
//   - reply-kind encoding and per-kind last byte index
//   - reply formatter state enum
//   - nibble_to_ascii(): 4-bit value to uppercase ASCII hex digit, also used
//     by the receive-side hex parser
package shell_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  localparam logic KIND_READ = 1'b0;
  localparam logic KIND_ERR  = 1'b1;

  // Index of the final byte of each reply ("AAAA DDDD\r\n" and "?\r\n").
  localparam logic [3:0] READ_LAST_IDX = 4'd10;
  localparam logic [3:0] ERR_LAST_IDX  = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte per frame.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_valid/i_byte  byte to send; taken when idle or on the frame-end cycle
//   o_tx            registered serial line, idle high
//   o_active        a frame is in progress
//   o_frame_end     high during the last cycle of the stop bit
// Handshake: i_valid has no ready; the producer asserts it only when
// o_active=0 or o_frame_end=1, and the byte is taken on that clock edge.
// Taking a byte on the frame-end cycle is what makes frames back-to-back.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_active,
  output logic       o_frame_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             active_q,  active_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;   // 0 start, 1..8 data, 9 stop
  logic [7:0]       shift_q,   shift_d;
  logic             tx_q,      tx_d;
  logic             frame_end;

  always_comb begin
    frame_end = active_q && (bit_cnt_q == 4'd9) && (clk_cnt_q == CNT_LAST);
    active_d  = active_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    if (i_valid && (!active_q || frame_end)) begin
      active_d  = 1'b1;
      clk_cnt_d = '0;
      bit_cnt_d = 4'd0;
      shift_d   = i_byte;
      tx_d      = 1'b0;
    end else if (active_q) begin
      if (clk_cnt_q == CNT_LAST) begin
        clk_cnt_d = '0;
        if (bit_cnt_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          // Leaving bit k: the next bit is data bit k (LSB first) or the stop bit.
          tx_d = (bit_cnt_q == 4'd8) ? 1'b1 : shift_q[bit_cnt_q[2:0]];
        end
      end else begin
        clk_cnt_d = clk_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      clk_cnt_q <= '0;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      active_q  <= active_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign o_tx        = tx_q;
  assign o_active    = active_q;
  assign o_frame_end = frame_end;

endmodule

// File: rtl/shell_reply_tx.sv
// shell_reply_tx: formats a shell reply as ASCII hex text and sends it on UART_TX.
//   read reply : "AAAA DDDD\r\n" (11 bytes), error reply: "?\r\n" (3 bytes)
// Ports:
//   CLK, RST          clock, synchronous active-low reset
//   i_Req             reply request, taken only while o_Busy=0
//   i_Kind            0 read reply, 1 error reply
//   i_Addr, i_Data    fields of a read reply, latched on acceptance
//   o_Busy            high from the cycle after acceptance until message end
//   o_Done            one-cycle pulse after the last stop bit
//   UART_TX           serial line, idle high
//   o_State           formatter state, for observation only
module shell_reply_tx
  import shell_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_Req,
  input  logic        i_Kind,
  input  logic [15:0] i_Addr,
  input  logic [15:0] i_Data,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        UART_TX,
  output logic [1:0]  o_State
);

  state_t      state_q, state_d;
  logic [3:0]  idx_q,   idx_d;
  logic        kind_q,  kind_d;
  logic [15:0] addr_q,  addr_d;
  logic [15:0] data_q,  data_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        ser_active;
  logic        ser_frame_end;
  logic [3:0]  last_idx;

  assign last_idx = (kind_q == KIND_ERR) ? ERR_LAST_IDX : READ_LAST_IDX;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    kind_d   = kind_q;
    addr_d   = addr_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tx_valid = 1'b0;
    case (state_q)
      // DONE accepts a request like IDLE so a reply can follow with no gap.
      ST_IDLE, ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (i_Req) begin
          state_d = ST_LOAD;
          idx_d   = 4'd0;
          kind_d  = i_Kind;
          addr_d  = i_Addr;
          data_d  = i_Data;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        tx_valid = 1'b1;
        if (!ser_active || ser_frame_end) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (ser_frame_end) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == last_idx) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tx_valid = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte mux: selects the byte the serializer takes on this edge, which is
  // the byte at the index being registered (idx_d).
  always_comb begin
    tx_byte = ASCII_LF;
    if (kind_q == KIND_ERR) begin
      case (idx_d)
        4'd0:    tx_byte = ASCII_QMARK;
        4'd1:    tx_byte = ASCII_CR;
        default: tx_byte = ASCII_LF;
      endcase
    end else begin
      case (idx_d)
        4'd0:    tx_byte = nibble_to_ascii(addr_q[15:12]);
        4'd1:    tx_byte = nibble_to_ascii(addr_q[11:8]);
        4'd2:    tx_byte = nibble_to_ascii(addr_q[7:4]);
        4'd3:    tx_byte = nibble_to_ascii(addr_q[3:0]);
        4'd4:    tx_byte = ASCII_SP;
        4'd5:    tx_byte = nibble_to_ascii(data_q[15:12]);
        4'd6:    tx_byte = nibble_to_ascii(data_q[11:8]);
        4'd7:    tx_byte = nibble_to_ascii(data_q[7:4]);
        4'd8:    tx_byte = nibble_to_ascii(data_q[3:0]);
        4'd9:    tx_byte = ASCII_CR;
        default: tx_byte = ASCII_LF;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      kind_q  <= KIND_READ;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk        (CLK),
    .rst_n      (RST),
    .i_valid    (tx_valid),
    .i_byte     (tx_byte),
    .o_tx       (UART_TX),
    .o_active   (ser_active),
    .o_frame_end(ser_frame_end)
  );

  assign o_Busy  = busy_q;
  assign o_Done  = done_q;
  assign o_State = state_q;

endmodule

// File: tb/tb_shell_reply_tx.sv
module tb_shell_reply_tx;

  localparam int CPB = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        i_Req = 1'b0;
  logic        i_Kind = 1'b0;
  logic [15:0] i_Addr = 16'h0;
  logic [15:0] i_Data = 16'h0;
  logic        o_Busy, o_Done, UART_TX;
  logic [1:0]  o_State;

  shell_reply_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .i_Req(i_Req), .i_Kind(i_Kind),
    .i_Addr(i_Addr), .i_Data(i_Data), .o_Busy(o_Busy), .o_Done(o_Done),
    .UART_TX(UART_TX), .o_State(o_State)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d required end", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int fall_q[$];
  int done_q[$];
  int done_busy_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // UART_RX loopback at the same bit rate, sampling mid-bit.
  logic       rx_on = 1'b0;
  int         rx_pos = 0;
  logic [7:0] rx_sh = 8'h00;
  always @(negedge CLK) begin
    if (o_Done) begin
      done_q.push_back(cyc);
      done_busy_q.push_back(int'(o_Busy));
    end
    if (!RST) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (UART_TX === 1'b0) begin
        rx_on = 1'b1;
        rx_pos = 0;
        fall_q.push_back(cyc);
      end
    end else begin
      rx_pos++;
      if (rx_pos % CPB == CPB / 2) begin
        int k;
        k = rx_pos / CPB;
        if (k == 0) check("start_bit", int'(UART_TX), 0);
        else if (k <= 8) rx_sh[k-1] = UART_TX;
        else begin
          check("stop_bit", int'(UART_TX), 1);
          rx_q.push_back(rx_sh);
          rx_on = 1'b0;
        end
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic              kind;
    logic [15:0]       addr;
    logic [15:0]       data;
    int                n;
    logic [0:10][7:0]  b;
  } vec_t;

  vec_t vecs[4];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic push_exp(input vec_t v, input int nbytes);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(v.b[i]);
  endtask

  task automatic clear_qs();
    fall_q.delete();
    done_q.delete();
    done_busy_q.delete();
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_bytes(input string name);
    int i = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (rx_q.size() == 0) check($sformatf("%s_missing%0d", name, i), -1, int'(e));
      else check($sformatf("%s_byte%0d", name, i), int'(rx_q.pop_front()), int'(e));
      i++;
    end
    check($sformatf("%s_extra_bytes", name), rx_q.size(), 0);
  endtask

  // Called at #1 after a rising edge; that cycle becomes T.
  task automatic start_req(input vec_t v, output int t);
    i_Req = 1'b1;
    i_Kind = v.kind;
    i_Addr = v.addr;
    i_Data = v.data;
    t = cyc;
    tick();
    i_Req = 1'b0;
    i_Kind = 1'($urandom_range(0, 1));
    i_Addr = 16'($urandom_range(0, 65535));
    i_Data = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("%s_done_seen", name), done_q.size(), target);
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc < c && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int t;
    clear_qs();
    check($sformatf("%s_busy_T", name), int'(o_Busy), 0);
    start_req(v, t);
    check($sformatf("%s_busy_T1", name), int'(o_Busy), 1);
    wait_done(1, 10 * 11 * CPB + 20, name);
    check($sformatf("%s_first_fall", name), q_at(fall_q, 0), t + 2);
    check($sformatf("%s_done_cyc", name), q_at(done_q, 0), t + 2 + 10 * v.n * CPB);
    check($sformatf("%s_busy_at_done", name), q_at(done_busy_q, 0), 0);
    repeat (5) tick();
    check($sformatf("%s_done_count", name), done_q.size(), 1);
    push_exp(v, v.n);
    check_bytes(name);
  endtask

  // ---------------- test ----------------
  initial begin
    int t, t2;
    vecs[0] = '{kind: 1'b0, addr: 16'h00A5, data: 16'hBEEF, n: 11,
                b: {8'h30, 8'h30, 8'h41, 8'h35, 8'h20, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A}};
    vecs[1] = '{kind: 1'b1, addr: 16'h1234, data: 16'h5678, n: 3,
                b: {8'h3F, 8'h0D, 8'h0A, 64'h0}};
    vecs[2] = '{kind: 1'b0, addr: 16'hFFFF, data: 16'h0000, n: 11,
                b: {8'h46, 8'h46, 8'h46, 8'h46, 8'h20, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}};
    vecs[3] = '{kind: 1'b0, addr: 16'h9A09, data: 16'h1C3E, n: 11,
                b: {8'h39, 8'h41, 8'h30, 8'h39, 8'h20, 8'h31, 8'h43, 8'h33, 8'h45, 8'h0D, 8'h0A}};

    // reset state
    RST = 1'b0;
    repeat (3) tick();
    check("rst_tx", int'(UART_TX), 1);
    check("rst_busy", int'(o_Busy), 0);
    check("rst_done", int'(o_Done), 0);
    check("rst_state", int'(o_State), 0);
    RST = 1'b1;
    repeat (3) tick();

    // table: single messages
    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      repeat (3) tick();
    end

    // request while busy (during byte 4) is dropped
    clear_qs();
    start_req(vecs[0], t);
    wait_cyc(t + 2 + 4 * 10 * CPB + 10);
    i_Req = 1'b1; i_Kind = 1'b1; i_Addr = 16'h4321; i_Data = 16'h8765;
    repeat (3) tick();
    i_Req = 1'b0;
    check("busy_drop_busy", int'(o_Busy), 1);
    wait_done(1, 500, "busy_drop");
    check("busy_drop_done_cyc", q_at(done_q, 0), t + 2 + 440);
    repeat (60) tick();
    check("busy_drop_done_count", done_q.size(), 1);
    check("busy_drop_idle_busy", int'(o_Busy), 0);
    push_exp(vecs[0], 11);
    check_bytes("busy_drop");

    // request in the o_Done cycle is accepted with no gap
    clear_qs();
    start_req(vecs[1], t);
    wait_cyc(t + 2 + 3 * 10 * CPB);
    check("chain_done_now", int'(o_Done), 1);
    check("chain_busy_now", int'(o_Busy), 0);
    start_req(vecs[3], t2);
    check("chain_busy_T1", int'(o_Busy), 1);
    wait_done(2, 500, "chain");
    check("chain_done0_cyc", q_at(done_q, 0), t + 2 + 120);
    check("chain_done1_cyc", q_at(done_q, 1), t2 + 2 + 440);
    check("chain_second_fall", q_at(fall_q, 3), t2 + 2);
    repeat (5) tick();
    check("chain_done_count", done_q.size(), 2);
    push_exp(vecs[1], 3);
    push_exp(vecs[3], 11);
    check_bytes("chain");

    // reset during byte 2 data bits aborts the message
    clear_qs();
    start_req(vecs[2], t);
    wait_cyc(t + 2 + 2 * 10 * CPB + 10);
    RST = 1'b0;
    tick();
    check("abort_tx", int'(UART_TX), 1);
    check("abort_busy", int'(o_Busy), 0);
    check("abort_done", int'(o_Done), 0);
    check("abort_state", int'(o_State), 0);
    tick();
    RST = 1'b1;
    repeat (40) tick();
    check("abort_no_done", done_q.size(), 0);
    check("abort_idle_tx", int'(UART_TX), 1);
    push_exp(vecs[2], 2);
    check_bytes("abort_partial");
    run_vec(vecs[0], "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
